// File: rtl/bf_core_stacked.sv
// Brainfuck execution core: code and data in separate 1-cycle-latency RAMs,
// a loop-return stack for single-step `]`, and valid/ready `.`/`,` streams.
module bf_core_stacked #(
  parameter int CODE_ADDR_W  = 9,
  parameter int ARRAY_ADDR_W = 9,
  parameter int CELL_W       = 8,
  parameter int STACK_DEPTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              data_code,
  output logic [CODE_ADDR_W-1:0]  addr_code,
  input  logic [CELL_W-1:0]       dataIn_array,
  output logic [ARRAY_ADDR_W-1:0] addr_array,
  output logic [CELL_W-1:0]       dataOut_array,
  output logic                    writeRq_array,
  output logic [CELL_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic [CELL_W-1:0]       in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    halted,
  output logic                    error
);
  localparam int SP_W = $clog2(STACK_DEPTH) + 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  typedef enum logic [2:0] {
    S_FETCH, S_EXEC, S_LOAD, S_SCAN, S_OUT_WAIT, S_IN_WAIT, S_HALT
  } state_t;

  state_t                  r_state, w_state_next;
  logic [CODE_ADDR_W-1:0]  r_pc, w_pc_next;
  logic [ARRAY_ADDR_W-1:0] r_ptr, w_ptr_next;
  logic [CELL_W-1:0]       r_cell, w_cell_next;
  logic [CELL_W-1:0]       r_dout, w_dout_next;
  logic                    r_wr, w_wr_next;
  logic [CELL_W-1:0]       r_out_data, w_out_data_next;
  logic                    r_out_valid, w_out_valid_next;
  logic                    r_in_ready, w_in_ready_next;
  logic                    r_halted, w_halted_next;
  logic                    r_error, w_error_next;
  logic [SP_W-1:0]         r_sp, w_sp_next;
  logic [CODE_ADDR_W-1:0]  r_depth, w_depth_next;
  logic                    r_scan_test, w_scan_test_next;
  logic                    w_push, w_advance, w_fault;
  logic [SP_W-1:0]         w_sp_dec;
  logic [CODE_ADDR_W-1:0]  w_top;
  logic [CODE_ADDR_W-1:0]  r_stack [STACK_DEPTH];

  assign w_sp_dec = r_sp - 1'b1;
  assign w_top    = r_stack[w_sp_dec[SP_W-2:0]];

  always_comb begin
    w_state_next     = r_state;
    w_pc_next        = r_pc;
    w_ptr_next       = r_ptr;
    w_cell_next      = r_cell;
    w_dout_next      = r_dout;
    w_wr_next        = 1'b0;
    w_out_data_next  = r_out_data;
    w_out_valid_next = r_out_valid;
    w_in_ready_next  = r_in_ready;
    w_halted_next    = r_halted;
    w_error_next     = r_error;
    w_sp_next        = r_sp;
    w_depth_next     = r_depth;
    w_scan_test_next = r_scan_test;
    w_push           = 1'b0;
    w_advance        = 1'b0;
    w_fault          = 1'b0;

    case (r_state)
      S_FETCH: w_state_next = S_EXEC;
      S_EXEC: begin
        case (data_code)
          8'h2B, 8'h2D: begin
            w_cell_next = (data_code == 8'h2B) ? r_cell + 1'b1 : r_cell - 1'b1;
            w_dout_next = w_cell_next;
            w_wr_next   = 1'b1;
            w_advance   = 1'b1;
          end
          8'h3E, 8'h3C: begin
            w_ptr_next   = (data_code == 8'h3E) ? r_ptr + 1'b1 : r_ptr - 1'b1;
            w_state_next = S_LOAD;
          end
          8'h5B: begin
            if (r_cell != '0) begin
              if (r_sp == SP_FULL) begin
                w_fault = 1'b1;
              end else begin
                w_push    = 1'b1;
                w_sp_next = r_sp + 1'b1;
                w_advance = 1'b1;
              end
            end else if (&r_pc) begin
              w_fault = 1'b1;
            end else begin
              w_pc_next        = r_pc + 1'b1;
              w_depth_next     = '0;
              w_scan_test_next = 1'b0;
              w_state_next     = S_SCAN;
            end
          end
          8'h5D: begin
            if (r_sp == '0) begin
              w_fault = 1'b1;
            end else if (r_cell != '0) begin
              // Jump straight past the matching `[`; its entry stays on the stack.
              w_pc_next    = w_top + 1'b1;
              w_state_next = S_FETCH;
            end else begin
              w_sp_next = w_sp_dec;
              w_advance = 1'b1;
            end
          end
          8'h2E: begin
            w_out_data_next  = r_cell;
            w_out_valid_next = 1'b1;
            w_state_next     = S_OUT_WAIT;
          end
          8'h2C: begin
            w_in_ready_next = 1'b1;
            w_state_next    = S_IN_WAIT;
          end
          8'h00: begin
            w_halted_next = 1'b1;
            w_state_next  = S_HALT;
          end
          default: w_advance = 1'b1;
        endcase
      end
      S_LOAD: begin
        w_cell_next = dataIn_array;
        w_advance   = 1'b1;
      end
      S_SCAN: begin
        if (!r_scan_test) begin
          w_scan_test_next = 1'b1;
        end else begin
          w_scan_test_next = 1'b0;
          if (data_code == 8'h00) begin
            w_fault = 1'b1;
          end else if (data_code == 8'h5D && r_depth == '0) begin
            w_advance = 1'b1;
          end else if (&r_pc) begin
            w_fault = 1'b1;
          end else begin
            w_pc_next = r_pc + 1'b1;
            if (data_code == 8'h5B)      w_depth_next = r_depth + 1'b1;
            else if (data_code == 8'h5D) w_depth_next = r_depth - 1'b1;
          end
        end
      end
      S_OUT_WAIT: begin
        if (out_ready) begin
          w_out_valid_next = 1'b0;
          w_advance        = 1'b1;
        end
      end
      S_IN_WAIT: begin
        if (in_valid && r_in_ready) begin
          w_cell_next     = in_data;
          w_dout_next     = in_data;
          w_wr_next       = 1'b1;
          w_in_ready_next = 1'b0;
          w_advance       = 1'b1;
        end
      end
      default: w_state_next = S_HALT;
    endcase

    // The last code address ends the program instead of wrapping to 0.
    if (w_fault) begin
      w_state_next  = S_HALT;
      w_halted_next = 1'b1;
      w_error_next  = 1'b1;
    end else if (w_advance) begin
      if (&r_pc) begin
        w_state_next  = S_HALT;
        w_halted_next = 1'b1;
      end else begin
        w_pc_next    = r_pc + 1'b1;
        w_state_next = S_FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_FETCH;
      r_pc        <= '0;
      r_ptr       <= '0;
      r_cell      <= '0;
      r_dout      <= '0;
      r_wr        <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
      r_halted    <= 1'b0;
      r_error     <= 1'b0;
      r_sp        <= '0;
      r_depth     <= '0;
      r_scan_test <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_ptr       <= w_ptr_next;
      r_cell      <= w_cell_next;
      r_dout      <= w_dout_next;
      r_wr        <= w_wr_next;
      r_out_data  <= w_out_data_next;
      r_out_valid <= w_out_valid_next;
      r_in_ready  <= w_in_ready_next;
      r_halted    <= w_halted_next;
      r_error     <= w_error_next;
      r_sp        <= w_sp_next;
      r_depth     <= w_depth_next;
      r_scan_test <= w_scan_test_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_stack[r_sp[SP_W-2:0]] <= r_pc;
  end

  // The array RAM sees the pointer being registered so LOAD gets the new cell.
  assign addr_array    = w_ptr_next;
  assign addr_code     = r_pc;
  assign dataOut_array = r_dout;
  assign writeRq_array = r_wr;
  assign out_data      = r_out_data;
  assign out_valid     = r_out_valid;
  assign in_ready      = r_in_ready;
  assign halted        = r_halted;
  assign error         = r_error;
endmodule

// File: tb/tb_bf_core_stacked.sv
// Directed bench: an 8-bit/8-deep core and a 4-bit/2-deep core run the same
// program from a shared code RAM, each with its own array RAM.
module tb_bf_core_stacked;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] data_code, dataIn_array, dataOut_array, out_data, in_data;
  logic [8:0] addr_code, addr_array;
  logic       writeRq_array, out_valid, out_ready, in_valid, in_ready, halted, error;

  logic [7:0] data_code_s;
  logic [3:0] dataIn_array_s, dataOut_array_s, out_data_s;
  logic [8:0] addr_code_s, addr_array_s;
  logic       writeRq_array_s, out_valid_s, in_ready_s, halted_s, error_s;

  bf_core_stacked u_dut (
    .clk(clk), .reset(reset), .data_code(data_code), .addr_code(addr_code),
    .dataIn_array(dataIn_array), .addr_array(addr_array), .dataOut_array(dataOut_array),
    .writeRq_array(writeRq_array), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .halted(halted), .error(error)
  );

  bf_core_stacked #(.CELL_W(4), .STACK_DEPTH(2)) u_dut_s (
    .clk(clk), .reset(reset), .data_code(data_code_s), .addr_code(addr_code_s),
    .dataIn_array(dataIn_array_s), .addr_array(addr_array_s), .dataOut_array(dataOut_array_s),
    .writeRq_array(writeRq_array_s), .out_data(out_data_s), .out_valid(out_valid_s),
    .out_ready(1'b1), .in_data(in_data[3:0]), .in_valid(in_valid), .in_ready(in_ready_s),
    .halted(halted_s), .error(error_s)
  );

  logic [7:0] code_mem [512];
  logic [7:0] arr8 [512];
  logic [3:0] arr4 [512];
  logic       arr_clr = 1'b0;

  always @(posedge clk) begin
    data_code   <= code_mem[addr_code];
    data_code_s <= code_mem[addr_code_s];
    if (arr_clr) begin
      for (int i = 0; i < 512; i++) begin
        arr8[i] <= '0;
        arr4[i] <= '0;
      end
    end else begin
      if (writeRq_array)   arr8[addr_array]   <= dataOut_array;
      if (writeRq_array_s) arr4[addr_array_s] <= dataOut_array_s;
    end
    dataIn_array   <= arr8[addr_array];
    dataIn_array_s <= arr4[addr_array_s];
  end

  int         wr_tot = 0, out_tot = 0, wr_burst = 0;
  logic       wr_prev = 1'b0;
  logic [7:0] out_last = '0;
  logic [3:0] out_last_s = '0;
  logic [8:0] wr_addr_last = '0;

  always @(posedge clk) begin
    if (writeRq_array) begin
      wr_tot       <= wr_tot + 1;
      wr_addr_last <= addr_array;
    end
    if (writeRq_array && wr_prev) wr_burst <= wr_burst + 1;
    wr_prev <= writeRq_array;
    if (out_valid && out_ready) begin
      out_tot  <= out_tot + 1;
      out_last <= out_data;
    end
    if (out_valid_s) out_last_s <= out_data_s;
  end

  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic do_reset(input string prog);
    reset   = 1'b0;
    arr_clr = 1'b1;
    for (int i = 0; i < 512; i++) code_mem[i] = 8'h00;
    for (int i = 0; i < prog.len(); i++) code_mem[i] = prog[i];
    repeat (2) @(negedge clk);
    arr_clr = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Cycles counted from reset release until the 8-bit core reports halted.
  task automatic run(input int max, output int hc);
    int cyc = 0;
    hc = 0;
    while ((!halted || !halted_s) && cyc < max) begin
      @(negedge clk);
      cyc++;
      if (halted && hc == 0) hc = cyc;
    end
    check("finish_in_budget", {31'd0, halted & halted_s}, 32'd1);
  endtask

  int w0, o0, hc, n, cyc;

  initial begin
    out_ready = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;

    #12;
    check("rst_ctrl", {9'd0, addr_code, addr_array, writeRq_array, out_valid, in_ready, halted, error}, 32'd0);
    check("rst_data", {16'd0, dataOut_array, out_data}, 32'd0);

    do_reset("+++.");
    w0 = wr_tot; o0 = out_tot;
    run(100, hc);
    check("t1_out", out_last, 32'd3);
    check("t1_out_cnt", out_tot - o0, 32'd1);
    check("t1_writes", wr_tot - w0, 32'd3);
    check("t1_flags", {halted, error}, 32'b10);
    check("t1_arr0", arr8[0], 32'd3);
    check("t1_small_out", out_last_s, 32'd3);
    w0 = wr_tot;
    repeat (5) @(negedge clk);
    check("t1_halt_quiet", {wr_tot - w0, 8'd0, out_valid, in_ready}, 32'd0);

    do_reset("-.");
    run(100, hc);
    check("t2_out8", out_last, 32'hFF);
    check("t2_out4", out_last_s, 32'hF);

    do_reset("<+");
    run(100, hc);
    check("t3_wr_addr", wr_addr_last, 32'd511);
    check("t3_arr511", arr8[511], 32'd1);
    check("t3_err", error, 32'd0);

    do_reset("++[>+++<-]>.");
    w0 = wr_tot;
    run(200, hc);
    check("t4_out", out_last, 32'd6);
    check("t4_small_out", out_last_s, 32'd6);
    check("t4_writes", wr_tot - w0, 32'd10);
    check("t4_cycles", hc, 32'd46);
    check("t4_arr1", arr8[1], 32'd6);

    do_reset("[+[+]+].");
    w0 = wr_tot;
    run(200, hc);
    check("t5_out", out_last, 32'd0);
    check("t5_writes", wr_tot - w0, 32'd0);
    check("t5_cycles", hc, 32'd19);
    check("t5_err", error, 32'd0);

    do_reset("+[[[");
    run(100, hc);
    check("t6_deep_err", {halted, error}, 32'b10);
    check("t6_shallow_err", {halted_s, error_s}, 32'b11);

    do_reset("]");
    run(100, hc);
    check("t7_err", {halted, error, halted_s, error_s}, 32'b1111);

    out_ready = 1'b0;
    in_data   = 8'hA5;
    do_reset(",.");
    w0 = wr_tot;
    n = 0; cyc = 0;
    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (in_ready) begin
        n++;
        if (n == 6) in_valid = 1'b1;
      end else if (n > 0) begin
        break;
      end
    end
    in_valid = 1'b0;
    check("t8_in_ready_cycles", n, 32'd6);
    n = 0; cyc = 0;
    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        check("t8_out_stable", out_data, 32'hA5);
        n++;
        if (n == 4) out_ready = 1'b1;
      end else if (n > 0) begin
        break;
      end
    end
    check("t8_out_valid_cycles", n, 32'd4);
    run(100, hc);
    check("t8_echo", out_last, 32'hA5);
    check("t8_arr0", arr8[0], 32'hA5);
    check("t8_writes", wr_tot - w0, 32'd1);
    check("t8_small_echo", out_last_s, 32'h5);

    out_ready = 1'b0;
    do_reset("+.");
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("t9_in_out_wait", out_valid, 32'd1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("t9_async_ctrl", {9'd0, addr_code, addr_array, writeRq_array, out_valid, in_ready, halted, error}, 32'd0);
    check("t9_async_data", {16'd0, dataOut_array, out_data}, 32'd0);
    out_ready = 1'b1;

    check("wr_never_back_to_back", wr_burst, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bf_core_stacked.md
Name: bf_core_stacked

Overview:
Second-generation brainfuck execution core with parametrised cell width, code/array address widths and loop depth. Code and data live in two separate synchronous RAMs with 1-cycle read latency. A hardware loop-return stack makes backward jumps on `]` single-step instead of a reverse scan. The core adds `.` and `,` I/O through valid/ready streams and reports halt and error status to the enclosing SoC.

Parameters:
CODE_ADDR_W, 9, code RAM address width
ARRAY_ADDR_W, 9, data array address width
CELL_W, 8, data cell width in bits; cell arithmetic is modulo 2^CELL_W
STACK_DEPTH, 8, loop-return stack entries (power of 2, >=2)

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  asynchronous, active-low reset
data_code  in  8  code RAM read data, valid the cycle after addr_code changes
addr_code  out  CODE_ADDR_W  code RAM address
dataIn_array  in  CELL_W  array RAM read data, 1-cycle latency
addr_array  out  ARRAY_ADDR_W  array RAM address
dataOut_array  out  CELL_W  array write data
writeRq_array  out  1  array write strobe, one cycle per write
out_data  out  CELL_W  `.` output value
out_valid  out  1  output valid, held until out_ready
out_ready  in  1  consumer accepts out_data
in_data  in  CELL_W  `,` input value
in_valid  in  1  producer offers in_data
in_ready  out  1  core waiting for input
halted  out  1  core stopped (end of code or error)
error  out  1  stop cause was stack overflow or unmatched `]`

Behaviour:
- Reset (async, reset=0):
  - All outputs 0.
  - Internal cell register = 0, stack pointer = 0, scan depth = 0.
  - State = FETCH.
  - Reset mid-instruction aborts it immediately; no write strobe is issued.
  - Array RAM contents are not cleared.
- Internal cell register always mirrors mem[addr_array]. `[` and `]` test this register, never dataIn_array.
- States: FETCH, EXEC, LOAD, SCAN, OUT_WAIT, IN_WAIT, HALT.
- Instruction timing:
  - FETCH: 1 cycle wait for data_code.
  - EXEC: decode data_code.
  - Basic instructions take FETCH + EXEC = 2 cycles.
- `+` / `-` in EXEC: cell <= cell±1 (wrap), dataOut_array <= same value, writeRq_array=1 for the next cycle only, addr_code+1.
- `>` / `<` in EXEC: addr_array±1 (wraps modulo 2^ARRAY_ADDR_W), then go to LOAD. In LOAD, cell <= dataIn_array at cycle end. Total 3 cycles.
- `[` in EXEC:
  - cell!=0: push addr_code onto stack, addr_code+1.
  - Stack full on push: halted=1, error=1 (overflow).
  - cell==0: go to SCAN with depth=0, addr_code+1.
- SCAN: 2 cycles per character (wait + test).
  - `[`: depth+1.
  - `]` with depth>0: depth-1.
  - `]` with depth==0: return to FETCH at the address after that `]`. The stack is unchanged.
  - 0x00 or code-address wrap during scan: halted=1, error=1.
- `]` in EXEC:
  - Stack empty: halted=1, error=1.
  - cell!=0: addr_code <= top+1, no pop. One-cycle jump, no scan.
  - cell==0: pop, addr_code+1.
- `.` in EXEC: out_data <= cell, out_valid=1, go to OUT_WAIT. Stay until out_ready sampled high. out_valid drops the following cycle, then addr_code+1 and FETCH. out_data is stable while out_valid is high.
- `,` in EXEC: in_ready=1, go to IN_WAIT. On the cycle in_valid && in_ready:
  - cell <= in_data, dataOut_array <= in_data, writeRq_array pulse.
  - in_ready drops, addr_code+1.
  - If in_valid was already high on entry, the transfer completes the first IN_WAIT cycle.
- 0x00 in EXEC: halted=1, error=0, go to HALT.
- Any other byte: comment, addr_code+1, 2 cycles.
- Code end: an instruction completing at addr_code = all-ones halts with error=0 instead of wrapping.
- HALT: absorbing until reset. No writes; out_valid and in_ready are 0.
- writeRq_array is never high in two consecutive cycles.

Test Plan:
- Program "+++." with out_ready=1 → out_data=3 with one out_valid pulse, then halted=1, error=0. Array[0]=3, 3 write strobes.
- CELL_W=4, program "-." → out_data=0xF. Program "<+" from pointer 0 → write to addr_array=2^ARRAY_ADDR_W−1.
- "++[>+++<-]>." → out_data=6. Stack peaks at depth 1. Each `]` taken jump costs exactly 2 cycles.
- "[+[+]+]." with cell=0 → nested scan skips to `.`, out_data=0, no array writes.
- STACK_DEPTH=2, "+[[[" → halted=1, error=1 on the third `[`. "]" alone → error=1.
- ",." with in_valid delayed 5 cycles and out_ready delayed 3 → in_ready high 6 cycles, echo equals in_data. Reset asserted during OUT_WAIT → all outputs 0 asynchronously.
